// File: rtl/gamma_module.sv
// gamma_module: per-channel gamma correction of 25-bit video words {Sync[3:0], R, G, B}.
// Latency: a word accepted on a strobe (nVDSYNC=0) appears on video_data_o two strobes later.
// Backpressure: none; nVDSYNC=1 freezes every register. Curve ROM built only with `GAMMA_TABLE_EN.
module gamma_module (
  input  logic        VCLK,
  input  logic        nRST,
  input  logic        nVDSYNC,
  input  logic [3:0]  gammaparams_i,
  input  logic [24:0] video_data_i,
  output logic [24:0] video_data_o
);

  logic        strobe;
  logic [24:0] s1_dat;    // accepted word, curve select registered alongside it
  logic [24:0] s2_dat;    // corrected word
  logic [24:0] corr_dat;  // combinational correction of s1_dat

  assign strobe = ~nVDSYNC;

`ifdef GAMMA_TABLE_EN
  logic [3:0] code_q;
  logic [6:0] gamma_rom [0:1023];
  logic       bypass;
  logic [2:0] curve_idx;

  // Constant ROM: 8 non-unity curves (codes 0-3 and 5-8), 128 entries each,
  // addressed {curve index, colour value}. Values fixed at elaboration.
  for (genvar ci = 0; ci < 8; ci++) begin : g_curve
    for (genvar v = 0; v < 128; v++) begin : g_entry
      localparam int  CODE   = (ci < 4) ? ci : ci + 1;
      localparam real GAMMA  = 0.80 + 0.05 * CODE;
      localparam real SCALED = 127.0 * ((v / 127.0) ** GAMMA);
      localparam int  RAW    = $rtoi(SCALED + 0.5);
      localparam int  VAL    = (RAW > 127) ? 127 : ((RAW < 0) ? 0 : RAW);
      assign gamma_rom[ci*128 + v] = 7'(VAL);
    end
  end

  // Stage 1: capture the word together with the code that applies to it.
  always_ff @(posedge VCLK) begin
    if (nRST) begin
      s1_dat <= '0;
      code_q <= '0;
    end else if (strobe) begin
      s1_dat <= video_data_i;
      code_q <= gammaparams_i;
    end
  end

  // Curve lookup: three read ports, sync bits pass straight through.
  always_comb begin
    bypass    = (code_q == 4'd4) || (code_q > 4'd8);
    curve_idx = (code_q < 4'd4) ? code_q[2:0] : 3'(code_q - 4'd1);
    corr_dat  = s1_dat;
    if (!bypass) begin
      corr_dat[20:14] = gamma_rom[{curve_idx, s1_dat[20:14]}];
      corr_dat[13:7]  = gamma_rom[{curve_idx, s1_dat[13:7]}];
      corr_dat[6:0]   = gamma_rom[{curve_idx, s1_dat[6:0]}];
    end
  end
`else
  logic gamma_unused;

  // Without the curve table the code input has no function.
  assign gamma_unused = ^gammaparams_i;

  // Stage 1: capture the word.
  always_ff @(posedge VCLK) begin
    if (nRST) begin
      s1_dat <= '0;
    end else if (strobe) begin
      s1_dat <= video_data_i;
    end
  end

  // No correction: the word travels unchanged.
  always_comb begin
    corr_dat = s1_dat;
  end
`endif

  // Stage 2 and output register: advance together on each strobe.
  always_ff @(posedge VCLK) begin
    if (nRST) begin
      s2_dat       <= '0;
      video_data_o <= '0;
    end else if (strobe) begin
      s2_dat       <= corr_dat;
      video_data_o <= s2_dat;
    end
  end

endmodule

// File: tb/tb_gamma_module.sv
// Testbench for gamma_module: directed cases plus random strobes/codes/words/resets,
// compared every cycle against a model built from the curve formula and a queue of
// accepted words (output = word accepted two strobes earlier).
module tb_gamma_module;

  logic        VCLK;
  logic        nRST;
  logic        nVDSYNC;
  logic [3:0]  gammaparams_i;
  logic [24:0] video_data_i;
  logic [24:0] video_data_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [24:0] pend[$];
  logic [24:0] exp_out;

  localparam logic [24:0] FLUSH = {4'h3, 7'h11, 7'h22, 7'h33};

  gamma_module dut (
    .VCLK          (VCLK),
    .nRST          (nRST),
    .nVDSYNC       (nVDSYNC),
    .gammaparams_i (gammaparams_i),
    .video_data_i  (video_data_i),
    .video_data_o  (video_data_o)
  );

  initial VCLK = 1'b0;
  always #5 VCLK = ~VCLK;

  task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference curve: round(127*(x/127)^g), half up, clamped.
  function automatic logic [6:0] curve(input logic [6:0] x, input logic [3:0] c);
    real g;
    real y;
    int  r;
    if (c == 4'd4 || c > 4'd8) return x;
`ifdef GAMMA_TABLE_EN
    g = 0.80 + 0.05 * c;
    y = 127.0 * ((real'(x) / 127.0) ** g);
    r = $rtoi(y + 0.5);
    if (r > 127) r = 127;
    if (r < 0) r = 0;
    return 7'(r);
`else
    g = 0.0;
    y = 0.0;
    r = 0;
    return x;
`endif
  endfunction

  function automatic logic [24:0] expect_word(input logic [24:0] w, input logic [3:0] c);
    return {w[24:21], curve(w[20:14], c), curve(w[13:7], c), curve(w[6:0], c)};
  endfunction

  // One clock: drive inputs, update the model at the edge, compare half a cycle later.
  task automatic cyc(input logic rst, input logic strb, input logic [3:0] c,
                     input logic [24:0] w, input string tag);
    nRST          = rst;
    nVDSYNC       = ~strb;
    gammaparams_i = c;
    video_data_i  = w;
    @(posedge VCLK);
    if (rst) begin
      pend.delete();
      exp_out = '0;
    end else if (strb) begin
      pend.push_back(expect_word(w, c));
      if (pend.size() > 2) exp_out = pend.pop_front();
    end
    @(negedge VCLK);
    check(tag, video_data_o, exp_out);
  endtask

  initial begin
    logic [24:0] w40;
    logic [24:0] exp_a;
    logic [24:0] exp_b;
    nRST          = 1'b1;
    nVDSYNC       = 1'b1;
    gammaparams_i = '0;
    video_data_i  = '0;
    exp_out       = '0;
    @(negedge VCLK);

    // Reset state, with strobe active too
    cyc(1'b1, 1'b1, 4'd5, 25'h1ABCDEF, "reset");
    cyc(1'b1, 1'b0, 4'd5, 25'h0123456, "reset");

    // Code 4 bypass, strobe every 4th cycle
    w40 = {4'hF, 7'h40, 7'h40, 7'h40};
    for (int i = 0; i < 12; i++) cyc(1'b0, (i % 4 == 3), 4'd4, w40, "strobe4");
    check("req022_bypass", video_data_o, w40);

    // Code changes 0 -> 8 on consecutive strobes
`ifdef GAMMA_TABLE_EN
    exp_a = {4'hA, 7'h49, 7'h49, 7'h49};
    exp_b = {4'hB, 7'h38, 7'h38, 7'h38};
`else
    exp_a = {4'hA, 7'h40, 7'h40, 7'h40};
    exp_b = {4'hB, 7'h40, 7'h40, 7'h40};
`endif
    cyc(1'b0, 1'b1, 4'd0, {4'hA, 7'h40, 7'h40, 7'h40}, "code0");
    cyc(1'b0, 1'b1, 4'd8, {4'hB, 7'h40, 7'h40, 7'h40}, "code8");
    cyc(1'b0, 1'b1, 4'd4, FLUSH, "flush");
    check("req027_code0", video_data_o, exp_a);
    cyc(1'b0, 1'b1, 4'd4, FLUSH, "flush");
    check("req027_code8", video_data_o, exp_b);

    // End points 0x00 and 0x7F fixed for codes 0..8
    for (int c = 0; c <= 8; c++) begin
      cyc(1'b0, 1'b1, 4'(c), {4'(c), 7'h00, 7'h7F, 7'h00}, "ends");
      if (c >= 2) check("req023_ends", video_data_o, {4'(c - 2), 7'h00, 7'h7F, 7'h00});
    end

    // Code 12 bypass
    cyc(1'b0, 1'b1, 4'd12, {4'h5, 7'h23, 7'h23, 7'h23}, "code12");
    cyc(1'b0, 1'b1, 4'd4, FLUSH, "flush");
    cyc(1'b0, 1'b1, 4'd4, FLUSH, "flush");
    check("req024_code12", video_data_o, {4'h5, 7'h23, 7'h23, 7'h23});

    // Hold: no strobe for 20 cycles while inputs toggle
    for (int i = 0; i < 20; i++)
      cyc(1'b0, 1'b0, 4'($urandom_range(0, 15)), 25'($urandom), "hold");

    // Reset with words in flight
    cyc(1'b0, 1'b1, 4'd4, {4'h7, 7'h01, 7'h02, 7'h03}, "inflight");
    cyc(1'b0, 1'b1, 4'd4, {4'h8, 7'h04, 7'h05, 7'h06}, "inflight");
    cyc(1'b1, 1'b0, 4'd4, FLUSH, "mid_reset");
    cyc(1'b0, 1'b0, 4'd4, FLUSH, "post_reset");
    cyc(1'b0, 1'b1, 4'd4, {4'h9, 7'h0A, 7'h0B, 7'h0C}, "post_s1");
    cyc(1'b0, 1'b0, 4'd4, FLUSH, "post_idle");
    cyc(1'b0, 1'b1, 4'd4, {4'hC, 7'h0D, 7'h0E, 7'h0F}, "post_s2");
    check("rst_flush", video_data_o, 25'h0);
    cyc(1'b0, 1'b1, 4'd4, FLUSH, "post_s3");
    check("rst_first", video_data_o, {4'h9, 7'h0A, 7'h0B, 7'h0C});

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), 25'($urandom), "random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
